// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the 64<->32 AXIS header insert/strip pair.
package axis_hdr_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t EMPTY = 2'd0;
  localparam state_t HDR   = 2'd1;
  localparam state_t LSB   = 2'd2;
  localparam state_t MSB   = 2'd3;

  localparam logic [STRB_W-1:0] STRB_FULL = 8'hFF;
  localparam logic [STRB_W-1:0] STRB_HALF = 8'h0F;

endpackage

// File: rtl/axis_64to32_tuser_hdr.sv
// 64->32 AXIS width converter that emits TUSER of the first beat as a leading header word.
module axis_64to32_tuser_hdr
  import axis_hdr_pkg::*;
#(
  parameter bit HDR_EN = 1'b1
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic [STRB_W-1:0] S_AXIS_TSTRB,
  input  logic              S_AXIS_TLAST,
  input  logic [WORD_W-1:0] S_AXIS_TUSER,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [WORD_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST
);

  state_t              state;
  logic                sop;
  logic [DATA_W-1:0]   data64;
  logic                upper_v;
  logic                last;
  logic [WORD_W-1:0]   hdr32;

  logic                beat_done;
  logic                s_xfr;
  logic                m_xfr;

  // Strobe is word-granular: only bit 4 selects whether the upper word exists.
  logic unused_strb;
  assign unused_strb = ^{S_AXIS_TSTRB[7:5], S_AXIS_TSTRB[3:0]};

  // Output decode; beat_done marks the cycle the final word of a held beat leaves.
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    beat_done     = 1'b0;
    case (state)
      HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = hdr32;
      end
      LSB: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = data64[WORD_W-1:0];
        M_AXIS_TLAST  = last & ~upper_v;
        beat_done     = M_AXIS_TREADY & ~upper_v;
      end
      MSB: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = data64[DATA_W-1:WORD_W];
        M_AXIS_TLAST  = last;
        beat_done     = M_AXIS_TREADY;
      end
      default: ;
    endcase
    S_AXIS_TREADY = AXIS_ARESETN & ((state == EMPTY) | beat_done);
    s_xfr         = S_AXIS_TVALID & S_AXIS_TREADY;
    m_xfr         = M_AXIS_TVALID & M_AXIS_TREADY;
  end

  // A new beat loads in EMPTY or in the beat-done cycle, so it never collides with a pending word.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state   <= EMPTY;
      sop     <= 1'b1;
      data64  <= '0;
      upper_v <= 1'b0;
      last    <= 1'b0;
      hdr32   <= '0;
    end else if (s_xfr) begin
      data64  <= S_AXIS_TDATA;
      upper_v <= S_AXIS_TSTRB[4];
      last    <= S_AXIS_TLAST;
      hdr32   <= S_AXIS_TUSER;
      sop     <= S_AXIS_TLAST;
      state   <= (sop & HDR_EN) ? HDR : LSB;
    end else if (m_xfr) begin
      case (state)
        HDR:     state <= LSB;
        LSB:     state <= upper_v ? MSB : EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_64to32_tuser_hdr.sv
// Randomised bench for axis_64to32_tuser_hdr with header (HDR_EN=1) and headerless (HDR_EN=0) instances.
module tb_axis_64to32_tuser_hdr;
  import axis_hdr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [63:0] s_tdata  [2];
  logic [7:0]  s_tstrb  [2];
  logic        s_tlast  [2];
  logic [31:0] s_tuser  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [31:0] m_tdata  [2];
  logic        m_tlast  [2];

  axis_64to32_tuser_hdr #(.HDR_EN(1'b1)) u_hdr (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TREADY(s_tready[1]), .S_AXIS_TDATA(s_tdata[1]),
    .S_AXIS_TSTRB(s_tstrb[1]), .S_AXIS_TLAST(s_tlast[1]), .S_AXIS_TUSER(s_tuser[1]),
    .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_tready[1]), .M_AXIS_TDATA(m_tdata[1]),
    .M_AXIS_TLAST(m_tlast[1])
  );

  axis_64to32_tuser_hdr #(.HDR_EN(1'b0)) u_nohdr (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TREADY(s_tready[0]), .S_AXIS_TDATA(s_tdata[0]),
    .S_AXIS_TSTRB(s_tstrb[0]), .S_AXIS_TLAST(s_tlast[0]), .S_AXIS_TUSER(s_tuser[0]),
    .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_tready[0]), .M_AXIS_TDATA(m_tdata[0]),
    .M_AXIS_TLAST(m_tlast[0])
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  strb;
    logic        last;
    logic [31:0] user;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
    int          kind;  // 0 header, 1 lower, 2 upper
  } word_t;

  beat_t       srcq [2][$];
  word_t       expq [2][$];
  logic [32:0] logq [2][$];
  bit          msop [2];
  bit          held [2];
  logic [31:0] held_d [2];
  logic        held_l [2];
  bit          s_acc [2];

  int gap_pct, rdy_pct;
  bit freeze_rdy1, arm_rst;
  bit b2b_mode, b2b_started;
  int idle_cnt;
  int checks, failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int d, input logic [63:0] data, input logic [7:0] strb,
                           input logic last, input logic [31:0] user);
    beat_t b;
    b.d = data; b.strb = strb; b.last = last; b.user = user;
    srcq[d].push_back(b);
  endtask

  task automatic push_rand_pkt(input int d);
    int nb;
    nb = int'($urandom_range(4, 1));
    for (int i = 0; i < nb; i++)
      push_beat(d, {$urandom, $urandom}, ($urandom_range(1) == 1) ? STRB_FULL : STRB_HALF,
                i == nb - 1, $urandom);
  endtask

  // Reference: a packet start contributes its TUSER as a header, then one or two data words.
  task automatic model_accept(input int d);
    beat_t b;
    word_t w;
    b = srcq[d][0];
    if (msop[d] && d == 1) begin
      w.d = b.user; w.last = 1'b0; w.kind = 0;
      expq[d].push_back(w);
    end
    w.d = b.d[31:0]; w.last = b.last && (b.strb != STRB_FULL); w.kind = 1;
    expq[d].push_back(w);
    if (b.strb == STRB_FULL) begin
      w.d = b.d[63:32]; w.last = b.last; w.kind = 2;
      expq[d].push_back(w);
    end
    msop[d] = b.last;
  endtask

  task automatic cycle();
    word_t w;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (held[d]) begin
        chk($sformatf("d%0d_stall_data", d), 64'(m_tdata[d]), 64'(held_d[d]));
        chk($sformatf("d%0d_stall_last", d), 64'(m_tlast[d]), 64'(held_l[d]));
      end
      if (!m_tvalid[d])
        chk($sformatf("d%0d_idle_zero", d), 64'({m_tlast[d], m_tdata[d]}), 64'd0);
      if (m_tvalid[d] && m_tready[d]) begin
        if (expq[d].size() == 0) begin
          checks++; failures++;
          $display("FAIL d%0d_extra_word: got %h expected no word", d, m_tdata[d]);
        end else begin
          w = expq[d].pop_front();
          chk($sformatf("d%0d_word_data", d), 64'(m_tdata[d]), 64'(w.d));
          chk($sformatf("d%0d_word_last", d), 64'(m_tlast[d]), 64'(w.last));
        end
        logq[d].push_back({m_tlast[d], m_tdata[d]});
      end
      held[d]   = m_tvalid[d] && !m_tready[d];
      held_d[d] = m_tdata[d];
      held_l[d] = m_tlast[d];
      s_acc[d]  = s_tvalid[d] && s_tready[d];
      if (s_acc[d]) model_accept(d);
    end
    if (b2b_mode) begin
      if (m_tvalid[1]) b2b_started = 1'b1;
      else if (b2b_started && (srcq[1].size() != 0 || expq[1].size() != 0)) idle_cnt++;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (s_acc[d]) begin
        void'(srcq[d].pop_front());
        s_tvalid[d] = 1'b0;
      end
      if (!s_tvalid[d] && srcq[d].size() > 0 && ($urandom_range(99) >= gap_pct))
        s_tvalid[d] = 1'b1;
      if (s_tvalid[d]) begin
        s_tdata[d] = srcq[d][0].d;
        s_tstrb[d] = srcq[d][0].strb;
        s_tlast[d] = srcq[d][0].last;
        s_tuser[d] = srcq[d][0].user;
      end else begin
        s_tdata[d] = {$urandom, $urandom};
        s_tstrb[d] = 8'($urandom);
        s_tlast[d] = 1'($urandom);
        s_tuser[d] = $urandom;
      end
      m_tready[d] = ($urandom_range(99) < rdy_pct);
    end
    if (arm_rst && m_tvalid[1] && expq[1].size() > 0 && expq[1][0].kind == 2)
      freeze_rdy1 = 1'b1;
    if (freeze_rdy1) m_tready[1] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((srcq[0].size() != 0 || srcq[1].size() != 0 ||
            expq[0].size() != 0 || expq[1].size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", expq[0].size() + expq[1].size());
    end
    repeat (3) cycle();
  endtask

  task automatic chk_log(input string name, input int d, input logic [32:0] exp[$]);
    chk({name, "_count"}, 64'(logq[d].size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < logq[d].size(); i++)
      chk($sformatf("%s_w%0d", name, i), 64'(logq[d][i]), 64'(exp[i]));
  endtask

  logic [32:0] lit [$];

  initial begin
    checks = 0; failures = 0;
    gap_pct = 0; rdy_pct = 100;
    freeze_rdy1 = 0; arm_rst = 0; b2b_mode = 0; b2b_started = 0; idle_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = 0; s_tdata[d] = '0; s_tstrb[d] = '0; s_tlast[d] = 0; s_tuser[d] = '0;
      m_tready[d] = 1; msop[d] = 1; held[d] = 0; s_acc[d] = 0;
    end

    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_reset_mvalid", d), 64'(m_tvalid[d]), 64'd0);
      chk($sformatf("d%0d_reset_sready", d), 64'(s_tready[d]), 64'd0);
      chk($sformatf("d%0d_reset_mdata", d), 64'({m_tlast[d], m_tdata[d]}), 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_empty_sready", d), 64'(s_tready[d]), 64'd1);

    // Directed 3-beat header packet plus headerless 0F/FF mix, full rate, no gaps.
    b2b_mode = 1; b2b_started = 0; idle_cnt = 0;
    push_beat(1, {32'hD0D00002, 32'hD0D00001}, STRB_FULL, 1'b0, 32'hCAFE0001);
    push_beat(1, {32'hD1D10002, 32'hD1D10001}, STRB_FULL, 1'b0, 32'hBAD00001);
    push_beat(1, {32'hD2D20002, 32'hD2D20001}, STRB_HALF, 1'b1, 32'hBAD00002);
    push_beat(0, {32'hF0F00002, 32'hF0F00001}, STRB_HALF, 1'b0, 32'h11111111);
    push_beat(0, {32'hF1F10002, 32'hF1F10001}, STRB_FULL, 1'b1, 32'h22222222);
    drain(200);
    lit = '{{1'b0, 32'hCAFE0001}, {1'b0, 32'hD0D00001}, {1'b0, 32'hD0D00002},
            {1'b0, 32'hD1D10001}, {1'b0, 32'hD1D10002}, {1'b1, 32'hD2D20001}};
    chk_log("t1_hdr_pkt", 1, lit);
    lit = '{{1'b0, 32'hF0F00001}, {1'b0, 32'hF1F10001}, {1'b1, 32'hF1F10002}};
    chk_log("t5_nohdr_pkt", 0, lit);
    chk("t1_b2b_idle", 64'(idle_cnt), 64'd0);

    // Two back-to-back single-beat packets each get their own header.
    logq[0].delete(); logq[1].delete();
    b2b_started = 0; idle_cnt = 0;
    push_beat(1, {32'hE0E00002, 32'hE0E00001}, STRB_FULL, 1'b1, 32'h00000042);
    push_beat(1, {32'hE1E10002, 32'hE1E10001}, STRB_FULL, 1'b1, 32'h00000043);
    drain(200);
    lit = '{{1'b0, 32'h00000042}, {1'b0, 32'hE0E00001}, {1'b1, 32'hE0E00002},
            {1'b0, 32'h00000043}, {1'b0, 32'hE1E10001}, {1'b1, 32'hE1E10002}};
    chk_log("t2_one_beat", 1, lit);
    chk("t2_b2b_idle", 64'(idle_cnt), 64'd0);
    b2b_mode = 0;

    // Random packets with random back-pressure and input gaps on both instances.
    gap_pct = 30; rdy_pct = 50;
    for (int i = 0; i < 100; i++) push_rand_pkt(1);
    for (int i = 0; i < 40; i++) push_rand_pkt(0);
    drain(20000);

    // Reset while the header instance is stalled on an upper word.
    gap_pct = 0; rdy_pct = 100;
    for (int i = 0; i < 3; i++)
      push_beat(1, {$urandom, $urandom}, STRB_FULL, i == 2, 32'h77770000 + 32'(i));
    arm_rst = 1;
    for (int n = 0; n < 100 && !freeze_rdy1; n++) cycle();
    chk("t6_reached_msb", 64'(freeze_rdy1), 64'd1);
    @(negedge clk);
    chk("t6_pre_reset_valid", 64'(m_tvalid[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mvalid", 64'(m_tvalid[1]), 64'd0);
    chk("t6_rst_sready", 64'(s_tready[1]), 64'd0);
    chk("t6_rst_mdata", 64'({m_tlast[1], m_tdata[1]}), 64'd0);
    for (int d = 0; d < 2; d++) begin
      srcq[d].delete(); expq[d].delete(); logq[d].delete();
      held[d] = 0; s_acc[d] = 0; msop[d] = 1; s_tvalid[d] = 0;
    end
    arm_rst = 0; freeze_rdy1 = 0; m_tready[1] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_beat(1, {32'h5EED0002, 32'h5EED00A1}, STRB_HALF, 1'b1, 32'h5EED0001);
    drain(200);
    lit = '{{1'b0, 32'h5EED0001}, {1'b1, 32'h5EED00A1}};
    chk_log("t6_after_reset", 1, lit);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
